// File: rtl/pong_pkg.sv
`default_nettype none
//============================================================================
// Package : pong_pkg
// Brief   : Shared screen geometry, FSM state and direction encodings for
//           the pong game-logic stage.
// Rev     : 1.0
//============================================================================
package pong_pkg;

    localparam int unsigned c_screen_w = 640;
    localparam int unsigned c_screen_h = 480;

    // Serve position: top-left corner that centres an 8-pixel ball.
    localparam logic [9:0] c_cx = 10'd316;
    localparam logic [9:0] c_cy = 10'd236;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // DIR_POS is right on the x axis and down on the y axis.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    function automatic logic paddle_overlap(
        input logic [9:0]  ball_y,
        input logic [9:0]  pad_y,
        input logic [10:0] ball_size,
        input logic [10:0] pad_h
    );
        return (({1'b0, ball_y} + ball_size) > {1'b0, pad_y}) &&
               ({1'b0, ball_y} < ({1'b0, pad_y} + pad_h));
    endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
//============================================================================
// Module : frame_tick_sync
// Brief  : Two-flop synchronizer plus rising-edge detector for endofframe.
// Rev    : 1.0
//============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_tick
);

    logic r_sync1_q;
    logic r_sync2_q;
    logic r_prev_q;
    logic w_sync1_d;
    logic w_sync2_d;
    logic w_prev_d;

    always_comb begin
        w_sync1_d = i_level;
        w_sync2_d = r_sync1_q;
        w_prev_d  = r_sync2_q;
    end

    // All flops reset high so a level already high at reset is not a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_prev_q  <= 1'b1;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_prev_q  <= w_prev_d;
        end
    end

    assign o_tick = r_sync2_q & ~r_prev_q;

endmodule : frame_tick_sync
`default_nettype wire

// File: rtl/pong_ball_engine.sv
`default_nettype none
//============================================================================
// Module : pong_ball_engine
// Brief  : Per-frame ball motion, wall/paddle bounces, scoring and the
//          serve / pause / game-over sequencing.
// Rev    : 1.0
//============================================================================
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int P1_X         = 5,
    parameter int P2_X         = 600,
    parameter int PAUSE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       endofframe,
    input  logic       serve,
    input  logic [9:0] paddle_one_y,
    input  logic [9:0] paddle_two_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       point_pulse,
    output logic       game_over
);

    localparam int c_cnt_w = (PAUSE_FRAMES > 2) ? $clog2(PAUSE_FRAMES) : 1;

    // 11-bit forms keep the edge compares free of wrap-around.
    localparam logic [10:0] c_size_w    = 11'(BALL_SIZE);
    localparam logic [10:0] c_speed_w   = 11'(BALL_SPEED);
    localparam logic [10:0] c_pad_h_w   = 11'(PADDLE_H);
    localparam logic [10:0] c_p1_edge_w = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] c_p2_x_w    = 11'(P2_X);
    localparam logic [10:0] c_scr_w_w   = 11'(c_screen_w);
    localparam logic [10:0] c_scr_h_w   = 11'(c_screen_h);

    localparam logic [9:0] c_speed   = 10'(BALL_SPEED);
    localparam logic [9:0] c_p1_edge = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] c_p2_stop = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] c_floor   = 10'(c_screen_h - BALL_SIZE);
    localparam logic [3:0] c_win     = 4'(WIN_SCORE);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PAUSE_FRAMES - 1);

    state_t              r_state_q, w_state_d;
    logic [9:0]          r_ball_x_q, w_ball_x_d;
    logic [9:0]          r_ball_y_q, w_ball_y_d;
    dir_t                r_dx_q, w_dx_d;
    dir_t                r_dy_q, w_dy_d;
    logic [3:0]          r_score_one_q, w_score_one_d;
    logic [3:0]          r_score_two_q, w_score_two_d;
    logic [c_cnt_w-1:0]  r_cnt_q, w_cnt_d;
    logic                r_armed_q, w_armed_d;
    logic                r_point_pulse_q, w_point_pulse_d;

    logic       w_tick;
    logic [9:0] w_x_step, w_y_step;
    dir_t       w_dx_step, w_dy_step;
    logic       w_hit_one, w_hit_two;
    logic       w_miss_left, w_miss_right;
    logic [3:0] w_score_one_inc, w_score_two_inc;
    logic       w_won;
    logic       w_game_over;

    frame_tick_sync u_frame_tick_sync (
        .clk     (clk50M),
        .rst     (reset),
        .i_level (endofframe),
        .o_tick  (w_tick)
    );

    // Candidate ball motion for this frame; only committed on a PLAY tick.
    always_comb begin
        w_hit_one    = paddle_overlap(r_ball_y_q, paddle_one_y, c_size_w, c_pad_h_w);
        w_hit_two    = paddle_overlap(r_ball_y_q, paddle_two_y, c_size_w, c_pad_h_w);
        w_y_step     = r_ball_y_q;
        w_dy_step    = r_dy_q;
        w_x_step     = r_ball_x_q;
        w_dx_step    = r_dx_q;
        w_miss_left  = 1'b0;
        w_miss_right = 1'b0;

        if (r_dy_q == DIR_NEG && {1'b0, r_ball_y_q} < c_speed_w) begin
            w_y_step  = '0;
            w_dy_step = DIR_POS;
        end else if (r_dy_q == DIR_POS &&
                     ({1'b0, r_ball_y_q} + c_size_w + c_speed_w) > c_scr_h_w) begin
            w_y_step  = c_floor;
            w_dy_step = DIR_NEG;
        end else if (r_dy_q == DIR_NEG) begin
            w_y_step = r_ball_y_q - c_speed;
        end else begin
            w_y_step = r_ball_y_q + c_speed;
        end

        if (r_dx_q == DIR_NEG) begin
            if ({1'b0, r_ball_x_q} >= c_p1_edge_w &&
                ({1'b0, r_ball_x_q} - c_speed_w) < c_p1_edge_w && w_hit_one) begin
                w_x_step  = c_p1_edge;
                w_dx_step = DIR_POS;
            end else if ({1'b0, r_ball_x_q} < c_speed_w) begin
                w_miss_left = 1'b1;
            end else begin
                w_x_step = r_ball_x_q - c_speed;
            end
        end else begin
            if (({1'b0, r_ball_x_q} + c_size_w) <= c_p2_x_w &&
                ({1'b0, r_ball_x_q} + c_size_w + c_speed_w) > c_p2_x_w && w_hit_two) begin
                w_x_step  = c_p2_stop;
                w_dx_step = DIR_NEG;
            end else if (({1'b0, r_ball_x_q} + c_size_w + c_speed_w) > c_scr_w_w) begin
                w_miss_right = 1'b1;
            end else begin
                w_x_step = r_ball_x_q + c_speed;
            end
        end
    end

    // Scores saturate at the winning value.
    always_comb begin
        w_score_one_inc = (r_score_one_q < c_win) ? r_score_one_q + 4'd1 : r_score_one_q;
        w_score_two_inc = (r_score_two_q < c_win) ? r_score_two_q + 4'd1 : r_score_two_q;
        w_won = w_miss_left ? (w_score_two_inc == c_win) : (w_score_one_inc == c_win);
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_state_q <= ST_SERVE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_SERVE: begin
                if (r_armed_q && serve) begin
                    w_state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_tick && (w_miss_left || w_miss_right)) begin
                    if (w_won) begin
                        w_state_d = ST_OVER;
                    end else begin
                        w_state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_tick && r_cnt_q == c_cnt_last) begin
                    w_state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (serve) begin
                    w_state_d = ST_SERVE;
                end
            end
            default: w_state_d = ST_SERVE;
        endcase
    end

    always_comb begin
        w_game_over = (r_state_q == ST_OVER);
    end

    // Datapath updates; the armed flag only survives while sitting in SERVE.
    always_comb begin
        w_ball_x_d      = r_ball_x_q;
        w_ball_y_d      = r_ball_y_q;
        w_dx_d          = r_dx_q;
        w_dy_d          = r_dy_q;
        w_score_one_d   = r_score_one_q;
        w_score_two_d   = r_score_two_q;
        w_cnt_d         = r_cnt_q;
        w_armed_d       = 1'b0;
        w_point_pulse_d = 1'b0;
        case (r_state_q)
            ST_SERVE: begin
                w_ball_x_d = c_cx;
                w_ball_y_d = c_cy;
                w_armed_d  = r_armed_q | ~serve;
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (w_miss_left || w_miss_right) begin
                        w_ball_x_d      = c_cx;
                        w_ball_y_d      = c_cy;
                        w_cnt_d         = '0;
                        w_point_pulse_d = 1'b1;
                        if (w_miss_left) begin
                            w_dx_d        = DIR_NEG;
                            w_score_two_d = w_score_two_inc;
                        end else begin
                            w_dx_d        = DIR_POS;
                            w_score_one_d = w_score_one_inc;
                        end
                    end else begin
                        w_ball_x_d = w_x_step;
                        w_ball_y_d = w_y_step;
                        w_dx_d     = w_dx_step;
                        w_dy_d     = w_dy_step;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_tick) begin
                    w_cnt_d = (r_cnt_q == c_cnt_last) ? '0 : r_cnt_q + c_cnt_w'(1);
                end
            end
            ST_OVER: begin
                w_ball_x_d = c_cx;
                w_ball_y_d = c_cy;
                if (serve) begin
                    w_score_one_d = '0;
                    w_score_two_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_ball_x_q      <= c_cx;
            r_ball_y_q      <= c_cy;
            r_dx_q          <= DIR_POS;
            r_dy_q          <= DIR_POS;
            r_score_one_q   <= '0;
            r_score_two_q   <= '0;
            r_cnt_q         <= '0;
            r_armed_q       <= 1'b0;
            r_point_pulse_q <= 1'b0;
        end else begin
            r_ball_x_q      <= w_ball_x_d;
            r_ball_y_q      <= w_ball_y_d;
            r_dx_q          <= w_dx_d;
            r_dy_q          <= w_dy_d;
            r_score_one_q   <= w_score_one_d;
            r_score_two_q   <= w_score_two_d;
            r_cnt_q         <= w_cnt_d;
            r_armed_q       <= w_armed_d;
            r_point_pulse_q <= w_point_pulse_d;
        end
    end

    assign ball_x      = r_ball_x_q;
    assign ball_y      = r_ball_y_q;
    assign score_one   = r_score_one_q;
    assign score_two   = r_score_two_q;
    assign point_pulse = r_point_pulse_q;
    assign game_over   = w_game_over;

endmodule : pong_ball_engine
`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
`default_nettype none
//============================================================================
// Module : tb_pong_ball_engine
// Brief  : Randomized game play against a frame-level reference model.
// Rev    : 1.0
//============================================================================
module tb_pong_ball_engine;

    localparam int BS = 8, SP = 2, PW = 10, PH = 60, P1X = 5, P2X = 600;
    localparam int PF = 60, WIN = 7, CX = 316, CY = 236;
    localparam int M_SERVE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

    logic       clk50M = 1'b0;
    logic       reset, endofframe, serve;
    logic [9:0] paddle_one_y, paddle_two_y;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_one, score_two;
    logic       point_pulse, game_over;

    pong_ball_engine dut (
        .clk50M       (clk50M),
        .reset        (reset),
        .endofframe   (endofframe),
        .serve        (serve),
        .paddle_one_y (paddle_one_y),
        .paddle_two_y (paddle_two_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score_one    (score_one),
        .score_two    (score_two),
        .point_pulse  (point_pulse),
        .game_over    (game_over)
    );

    always #10 clk50M = ~clk50M;

    int n_checks = 0;
    int n_fail   = 0;
    int g_frame  = 0;

    // Reference model: game state at frame granularity.
    int m_mode, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pause_left;
    bit m_missed;
    bit trk_one, trk_two;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d frame=%0d", tag, got, exp, g_frame);
        end
    endtask

    task automatic model_reset();
        m_mode = M_SERVE; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_pause_left = 0; m_missed = 0;
    endtask

    task automatic model_tick(input int p1, input int p2);
        int ny, ndy, nx, ndx;
        bit lm, rm, ov1, ov2;
        m_missed = 0;
        if (m_mode == M_PLAY) begin
            ndy = m_dy;
            if (m_dy < 0 && m_y < SP) begin ny = 0; ndy = 1; end
            else if (m_dy > 0 && m_y + BS + SP > 480) begin ny = 480 - BS; ndy = -1; end
            else ny = m_y + SP * m_dy;
            ov1 = (m_y + BS > p1) && (m_y < p1 + PH);
            ov2 = (m_y + BS > p2) && (m_y < p2 + PH);
            lm = 0; rm = 0; nx = m_x; ndx = m_dx;
            if (m_dx < 0) begin
                if (m_x >= P1X + PW && m_x - SP < P1X + PW && ov1) begin nx = P1X + PW; ndx = 1; end
                else if (m_x < SP) lm = 1;
                else nx = m_x - SP;
            end else begin
                if (m_x + BS <= P2X && m_x + BS + SP > P2X && ov2) begin nx = P2X - BS; ndx = -1; end
                else if (m_x + BS + SP > 640) rm = 1;
                else nx = m_x + SP;
            end
            if (lm || rm) begin
                m_missed = 1;
                m_x = CX; m_y = CY;
                m_dx = lm ? -1 : 1;
                if (lm) m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2;
                else    m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1;
                if ((lm ? m_s2 : m_s1) == WIN) m_mode = M_OVER;
                else begin m_mode = M_PAUSE; m_pause_left = PF; end
            end else begin
                m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
            end
        end else if (m_mode == M_PAUSE) begin
            m_pause_left--;
            if (m_pause_left == 0) m_mode = M_SERVE;
        end
    endtask

    task automatic model_press();
        if (m_mode == M_SERVE) m_mode = M_PLAY;
        else if (m_mode == M_OVER) begin m_s1 = 0; m_s2 = 0; m_mode = M_SERVE; end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"}, ball_x, m_x);
        chk({tag, "_y"}, ball_y, m_y);
        chk({tag, "_s1"}, score_one, m_s1);
        chk({tag, "_s2"}, score_two, m_s2);
        chk({tag, "_over"}, game_over, (m_mode == M_OVER) ? 1 : 0);
    endtask

    function automatic int pick_paddle(input bit track);
        int p;
        if (track) begin
            p = m_y - int'($urandom_range(0, 50));
            if (p < 0) p = 0;
        end else begin
            p = int'($urandom_range(0, 1023));
        end
        return p;
    endfunction

    // One video frame: 4 cycles high (tick lands inside), 3 cycles low.
    task automatic run_frame();
        int p1, p2, pulses, odx;
        pulses = 0;
        p1 = pick_paddle(trk_one);
        p2 = pick_paddle(trk_two);
        paddle_one_y = 10'(p1);
        paddle_two_y = 10'(p2);
        endofframe = 1'b1;
        repeat (4) begin
            @(negedge clk50M);
            if (point_pulse === 1'b1) pulses++;
        end
        odx = m_dx;
        model_tick(p1, p2);
        chk("hi_x", ball_x, m_x);
        chk("hi_y", ball_y, m_y);
        endofframe = 1'b0;
        repeat (3) begin
            @(negedge clk50M);
            if (point_pulse === 1'b1) pulses++;
        end
        check_all("frame");
        chk("pulse_cycles", pulses, m_missed ? 1 : 0);
        if (m_missed || odx != m_dx) begin
            trk_one = ($urandom_range(0, 2) == 0);
            trk_two = ($urandom_range(0, 2) == 0);
        end
        g_frame++;
    endtask

    task automatic press_serve();
        serve = 1'b0;
        repeat (2) @(negedge clk50M);
        serve = 1'b1;
        repeat (3) @(negedge clk50M);
        serve = 1'b0;
        repeat (2) @(negedge clk50M);
        model_press();
        check_all("press");
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog timeout frame=%0d", g_frame);
        $fatal(1, "watchdog");
    end

    initial begin
        int frames;
        reset = 1'b1; serve = 1'b0; endofframe = 1'b0;
        paddle_one_y = '0; paddle_two_y = '0;
        trk_one = 1'b1; trk_two = 1'b0;
        repeat (3) @(negedge clk50M);
        reset = 1'b0;
        model_reset();
        @(negedge clk50M);
        chk("rst_x", ball_x, 316);
        chk("rst_y", ball_y, 236);
        chk("rst_s1", score_one, 0);
        chk("rst_s2", score_two, 0);
        chk("rst_pulse", point_pulse, 0);
        chk("rst_over", game_over, 0);

        run_frame();
        run_frame();
        press_serve();
        for (int i = 0; i < 10; i++) run_frame();
        chk("serve10_x", ball_x, 336);
        chk("serve10_y", ball_y, 256);

        frames = 0;
        while (m_mode != M_OVER && frames < 8000) begin
            run_frame();
            frames++;
            if (m_mode == M_SERVE) begin
                if ($urandom_range(0, 2) == 0) press_serve();
            end else if (m_mode == M_PAUSE) begin
                if ($urandom_range(0, 3) == 0) press_serve();
            end else if (m_mode == M_PLAY) begin
                if ($urandom_range(0, 39) == 0) press_serve();
            end
        end
        chk("game_over_set", game_over, 1);
        chk("winner_score", (score_one > score_two) ? score_one : score_two, WIN);
        repeat (3) run_frame();
        press_serve();
        chk("cleared_s1", score_one, 0);
        chk("cleared_s2", score_two, 0);
        chk("cleared_over", game_over, 0);

        press_serve();
        frames = 0;
        while (!(m_mode == M_PLAY && m_x == 500) && frames < 400) begin
            run_frame();
            frames++;
            if (m_mode == M_SERVE) press_serve();
        end

        serve = 1'b1;
        reset = 1'b1;
        @(negedge clk50M);
        reset = 1'b0;
        model_reset();
        chk("midrst_x", ball_x, 316);
        chk("midrst_y", ball_y, 236);
        chk("midrst_s1", score_one, 0);
        chk("midrst_s2", score_two, 0);
        chk("midrst_over", game_over, 0);
        chk("midrst_pulse", point_pulse, 0);
        repeat (3) run_frame();
        chk("held_serve_x", ball_x, 316);
        press_serve();
        repeat (5) run_frame();
        chk("restart_x", ball_x, 326);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pong_ball_engine
`default_nettype wire

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Game-logic stage that drives the VGA drawing stage: produces ball_x, ball_y and scores, and consumes that stage's endofframe.
- Advances the ball once per video frame and handles bounces off the walls and paddles.
- Detects misses, keeps score, and sequences serve, point pause and game-over.
- Paddle positions come from the paddle controllers. All coordinates are visible-area pixels (x 0..639, y 0..479), with the ball position as its top-left corner.

Parameters:
- BALL_SIZE, 8: ball edge length in pixels.
- BALL_SPEED, 2: pixels moved per frame on each axis.
- PADDLE_W, 10: paddle width.
- PADDLE_H, 60: paddle height.
- P1_X, 5: left paddle left edge.
- P2_X, 600: right paddle left edge.
- PAUSE_FRAMES, 60: frames frozen after a point.
- WIN_SCORE, 7: score that ends the game.

Ports:
- clk50M  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- endofframe  in  1  frame marker from the VGA timing stage. Level signal; only its rising edge is used.
- serve  in  1  button, already debounced; level.
- paddle_one_y  in  10  left paddle top edge.
- paddle_two_y  in  10  right paddle top edge.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- score_one  out  4  left player score.
- score_two  out  4  right player score.
- point_pulse  out  1  one-cycle strobe when a point is awarded.
- game_over  out  1  high while in state OVER.

Behaviour:
- Single clock domain. reset is sampled on the clk50M rising edge only.
- Reset values:
  - ball_x = 316, ball_y = 236 (centre, CX/CY).
  - score_one = 0, score_two = 0.
  - dx = right, dy = down.
  - point_pulse = 0, game_over = 0.
  - state = SERVE, pause counter = 0, edge-detect flop = 1. The flop is set to 1 so an endofframe that is already high at reset is not treated as a tick.
- Frame tick: a one-cycle internal pulse on the 0->1 transition of endofframe, built from a 2-flop synchronizer plus an edge flop.
  - Ball state changes only on a tick cycle, except for the SERVE exit and reset.
- State SERVE: ball is held at CX/CY. When serve = 1, go to PLAY; dx/dy keep their current values.
- State PLAY, on each tick, evaluate in this priority order.
  - Vertical:
    - dy up and y < BALL_SPEED -> y = 0, dy = down.
    - dy down and y + BALL_SIZE + BALL_SPEED > 480 -> y = 480 - BALL_SIZE, dy = up.
    - Otherwise y moves by ±BALL_SPEED.
  - Overlap with paddle P: (y + BALL_SIZE > paddle_y) and (y < paddle_y + PADDLE_H), using 11-bit unsigned compares.
  - Left paddle (dx left):
    - Bounce when x >= P1_X + PADDLE_W, x - BALL_SPEED < P1_X + PADDLE_W, and overlap with paddle_one -> x = P1_X + PADDLE_W, dx = right.
    - Otherwise, if x < BALL_SPEED -> miss: score_two increments.
    - Otherwise x -= BALL_SPEED.
  - Right paddle (dx right), mirror of the left:
    - Bounce when x + BALL_SIZE <= P2_X, x + BALL_SIZE + BALL_SPEED > P2_X, and overlap with paddle_two -> x = P2_X - BALL_SIZE, dx = left.
    - Miss when x + BALL_SIZE + BALL_SPEED > 640: score_one increments.
  - The vertical and horizontal updates in the same tick are independent, so a corner hit reflects both axes in that tick.
  - Paddle positions are sampled on the tick cycle itself.
- On a miss:
  - point_pulse = 1 for exactly one clk50M cycle.
  - Ball is recentred to CX/CY.
  - dx points toward the player who lost the point; dy is unchanged.
  - If the new score equals WIN_SCORE -> OVER; otherwise -> PAUSE with counter = 0.
- State PAUSE: counter increments on each tick. When counter = PAUSE_FRAMES - 1 on a tick -> SERVE. serve is ignored while in PAUSE.
- State OVER: game_over = 1, ball held at CX/CY. When serve = 1 -> both scores cleared, game_over = 0, go to SERVE.
  - serve must return to 0 before a play starts: SERVE only leaves on serve = 1 after serve has been seen at 0 since entry (rearm flag).
- Scores saturate at WIN_SCORE and never wrap.
- Reset asserted mid-play overrides all other activity in the same cycle.

Decomposition:
- Shared package pong_pkg:
  - Screen constants 640/480.
  - CX/CY.
  - State encoding: SERVE, PLAY, PAUSE, OVER.
  - Direction encoding.
- Natural sub-module: frame_tick_sync, containing the synchronizer and rising-edge detector, with a 1-bit tick output.

Test Plan:
- Reset, then serve pulse, then 10 ticks -> ball_x = 336, ball_y = 256. No movement occurs between ticks while endofframe is held high.
- Top wall: ball_y = 1, dy up, tick -> ball_y = 0, dy down. The next tick gives ball_y = 2.
- Left paddle hit: ball_x = 16, dx left, paddle_one_y = 200, ball_y = 220, tick -> ball_x = 15, dx right. No point_pulse.
- Left miss: ball_x = 1, dx left, paddle_one_y = 0, ball_y = 300, tick -> point_pulse for exactly 1 cycle, score_two = 1, ball at 316/236, dx left. After 60 ticks the state returns to SERVE.
- Game over: score_one = 6, right miss -> score_one = 7, game_over = 1. Further ticks do not move the ball. serve press -> scores 0, game_over = 0.
- Reset asserted mid-PLAY at ball_x = 500 -> next cycle ball_x = 316, scores 0, state SERVE. A held serve does not start play until it has been released.
